// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: per-channel synchroniser, lockout FSM, registered
// rise/fall event pulses and an optional long-press pulse, all paced by a shared tick.
module debounce_multi #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned DEBOUNCE_TICKS = 4096,
    parameter int unsigned LONG_TICKS     = 131072,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                tp_i,
    input  logic [CHANNELS-1:0] btn_i,
    output logic [CHANNELS-1:0] btn_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [CHANNELS-1:0] long_o
);

    typedef enum logic [1:0] {
        S_WAIT_LOW  = 2'd0,
        S_CNT_HIGH  = 2'd1,
        S_WAIT_HIGH = 2'd2,
        S_CNT_LOW   = 2'd3
    } state_t;

    localparam int unsigned     CntW     = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(DEBOUNCE_TICKS - 1);
    localparam int unsigned     LongW    = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
    localparam logic [LongW-1:0] LongMax = LongW'(LONG_TICKS);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        state_t                 r_state;
        state_t                 w_state_d;
        logic [CntW-1:0]        r_cnt;
        logic [CntW-1:0]        w_cnt_d;
        logic                   w_high_q;
        logic                   w_high_d;
        logic                   r_rise;
        logic                   r_fall;

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_sync <= '0;
            end else begin
                r_sync[0] <= btn_i[k];
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    r_sync[i] <= r_sync[i-1];
                end
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_state <= S_WAIT_LOW;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_d;
                r_cnt   <= w_cnt_d;
            end
        end

        // Counting states ignore w_s entirely; that lockout is what swallows bounce.
        always_comb begin
            w_state_d = r_state;
            w_cnt_d   = r_cnt;
            unique case (r_state)
                S_WAIT_LOW: begin
                    if (w_s) begin
                        w_state_d = S_CNT_HIGH;
                        w_cnt_d   = '0;
                    end
                end
                S_CNT_HIGH: begin
                    if (tp_i) begin
                        if (r_cnt == CntLast) w_state_d = S_WAIT_HIGH;
                        else                  w_cnt_d   = r_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!w_s) begin
                        w_state_d = S_CNT_LOW;
                        w_cnt_d   = '0;
                    end
                end
                S_CNT_LOW: begin
                    if (tp_i) begin
                        if (r_cnt == CntLast) w_state_d = S_WAIT_LOW;
                        else                  w_cnt_d   = r_cnt + 1'b1;
                    end
                end
            endcase
        end

        assign w_high_q = (r_state == S_CNT_HIGH) || (r_state == S_WAIT_HIGH);
        assign w_high_d = (w_state_d == S_CNT_HIGH) || (w_state_d == S_WAIT_HIGH);

        // Decoded from the next state so the pulses line up with the btn_o edge.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= w_high_d & ~w_high_q;
                r_fall <= ~w_high_d & w_high_q;
            end
        end

        assign btn_o[k]  = w_high_q;
        assign rise_o[k] = r_rise;
        assign fall_o[k] = r_fall;

        if (LONG_TICKS > 0) begin : g_long
            logic [LongW-1:0] r_lcnt;
            logic             r_long;

            // Saturating at LongMax makes the pulse one-shot until the button is released.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_lcnt <= '0;
                    r_long <= 1'b0;
                end else if (!w_high_q) begin
                    r_lcnt <= '0;
                    r_long <= 1'b0;
                end else begin
                    r_long <= tp_i && (r_lcnt == LongMax - 1'b1);
                    if (tp_i && (r_lcnt != LongMax)) begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
            end

            assign long_o[k] = r_long;
        end else begin : g_no_long
            assign long_o[k] = 1'b0;
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus random stimulus
// compared against a tick-counting behavioural model of each channel.
module tb_debounce_multi;

    localparam int unsigned CH = 4;
    localparam int unsigned DT = 8;
    localparam int unsigned LT = 32;
    localparam int unsigned SS = 2;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          tp   = 1'b0;
    logic [CH-1:0] btn  = '0;
    logic [CH-1:0] btn_o;
    logic [CH-1:0] rise_o;
    logic [CH-1:0] fall_o;
    logic [CH-1:0] long_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit tp_always = 1'b0;

    // Model: raw-input history, debounced level, remaining lockout ticks, ticks held high.
    logic [SS-1:0] m_sync [CH];
    logic [CH-1:0] m_level;
    int            m_lock [CH];
    int            m_held [CH];
    logic [CH-1:0] exp_rise;
    logic [CH-1:0] exp_fall;
    logic [CH-1:0] exp_long;

    debounce_multi #(
        .CHANNELS      (CH),
        .DEBOUNCE_TICKS(DT),
        .LONG_TICKS    (LT),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .tp_i  (tp),
        .btn_i (btn),
        .btn_o (btn_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .long_o(long_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_sync[k] = '0;
            m_lock[k] = 0;
            m_held[k] = 0;
        end
        m_level  = '0;
        exp_rise = '0;
        exp_fall = '0;
        exp_long = '0;
    endtask

    task automatic model_step();
        logic old_l;
        logic s;
        for (int k = 0; k < CH; k++) begin
            old_l       = m_level[k];
            s           = m_sync[k][SS-1];
            exp_long[k] = 1'b0;
            if (old_l) begin
                if (tp && m_held[k] < int'(LT)) begin
                    m_held[k]++;
                    if (m_held[k] == int'(LT)) exp_long[k] = 1'b1;
                end
            end else begin
                m_held[k] = 0;
            end
            if (m_lock[k] > 0) begin
                if (tp) m_lock[k]--;
            end else if (s != old_l) begin
                m_level[k] = s;
                m_lock[k]  = DT;
            end
            exp_rise[k] = m_level[k] & ~old_l;
            exp_fall[k] = ~m_level[k] & old_l;
            m_sync[k]   = {m_sync[k][SS-2:0], btn[k]};
        end
    endtask

    // One clock: present tp, advance the model on pre-edge inputs, sample 1 after the edge.
    task automatic tick();
        tp = tp_always || (cyc % 4 == 0);
        if (rstn) model_step();
        else      model_reset();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_btn(input int ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (btn_o[ch]) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        btn  = 4'hF;
        model_reset();
        run(4);
        checks++;
        if ({btn_o, rise_o, fall_o, long_o} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0000", {btn_o, rise_o, fall_o, long_o});
        end
        rstn = 1'b1;
        run(2);
        checks++;
        if (btn_o !== 4'h0 || rise_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_latency_early: btn_o=%h rise_o=%h want 0 0", btn_o, rise_o);
        end
        tick();
        checks++;
        if (btn_o !== 4'hF || rise_o !== 4'hF) begin
            errors++;
            $display("FAIL reset_release_rise: btn_o=%h rise_o=%h want f f", btn_o, rise_o);
        end
        tick();
        checks++;
        if (btn_o !== 4'hF || rise_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_rise_width: btn_o=%h rise_o=%h want f 0", btn_o, rise_o);
        end
    endtask

    task automatic test_bounce();
        int n_rise = 0;
        int n_fall = 0;
        bit seen   = 1'b0;
        bit dropped = 1'b0;
        btn = '0;
        run(80);
        btn[0] = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (i > 0 && i <= 20 && i % 3 == 0) btn[0] = ~btn[0];
            if (i == 21) btn[0] = 1'b1;
            tick();
            if (rise_o[0]) n_rise++;
            if (fall_o[0]) n_fall++;
            if (seen && !btn_o[0]) dropped = 1'b1;
            if (btn_o[0]) seen = 1'b1;
        end
        checks++;
        if (n_rise != 1) begin
            errors++;
            $display("FAIL bounce_rise_count: got %0d want 1", n_rise);
        end
        checks++;
        if (n_fall != 0) begin
            errors++;
            $display("FAIL bounce_fall_count: got %0d want 0", n_fall);
        end
        checks++;
        if (dropped || btn_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_level: dropped=%0d btn_o0=%b want 0 1", dropped, btn_o[0]);
        end
    endtask

    task automatic test_lockout();
        bit ok;
        bit bad = 1'b0;
        int tpn = 0;
        int guard = 0;
        btn = '0;
        run(80);
        btn[1] = 1'b1;
        wait_btn(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lockout_rise_timeout: btn_o=%h want bit1 set", btn_o);
        end
        while (tpn < int'(DT) && guard < 64) begin
            tick();
            guard++;
            if (guard == 2) btn[1] = 1'b0;
            if (tp) tpn++;
            if (btn_o[1] !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL lockout_hold: btn_o[1] dropped early, got 0 want 1");
        end
        tick();
        checks++;
        if (btn_o[1] !== 1'b0 || fall_o !== 4'b0010) begin
            errors++;
            $display("FAIL lockout_drop: btn_o1=%b fall_o=%h want 0 2", btn_o[1], fall_o);
        end
        tick();
        checks++;
        if (fall_o !== 4'h0) begin
            errors++;
            $display("FAIL lockout_fall_width: fall_o=%h want 0", fall_o);
        end
    endtask

    task automatic test_long();
        bit ok;
        int tpn = 0;
        int n_long = 0;
        int at_tp = -1;
        btn = '0;
        run(80);
        btn[2] = 1'b1;
        wait_btn(2, ok);
        for (int i = 0; i < 160; i++) begin
            tick();
            if (tp) tpn++;
            if (long_o[2]) begin
                n_long++;
                at_tp = tpn;
            end
        end
        checks++;
        if (!ok || n_long != 1 || at_tp != int'(LT)) begin
            errors++;
            $display("FAIL long_first: ok=%0d count=%0d at_tp=%0d want 1 1 %0d",
                     ok, n_long, at_tp, LT);
        end
        btn[2] = 1'b0;
        n_long = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (long_o[2]) n_long++;
        end
        checks++;
        if (n_long != 0) begin
            errors++;
            $display("FAIL long_release: count=%0d want 0", n_long);
        end
        btn[2] = 1'b1;
        wait_btn(2, ok);
        for (int i = 0; i < 144; i++) begin
            tick();
            if (long_o[2]) n_long++;
        end
        checks++;
        if (!ok || n_long != 1) begin
            errors++;
            $display("FAIL long_second: ok=%0d count=%0d want 1 1", ok, n_long);
        end
        btn[2] = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit bad = 1'b0;
        int tpn = 0;
        btn = '0;
        run(80);
        btn[3] = 1'b1;
        wait_btn(3, ok);
        for (int i = 0; i < 64 && tpn < 5; i++) begin
            tick();
            if (tp) tpn++;
        end
        #2;
        rstn   = 1'b0;
        btn[3] = 1'b0;
        model_reset();
        #1;
        checks++;
        if (!ok || {btn_o, rise_o, fall_o, long_o} !== 16'h0) begin
            errors++;
            $display("FAIL midreset_outputs: ok=%0d got %h want 0000", ok,
                     {btn_o, rise_o, fall_o, long_o});
        end
        run(3);
        rstn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (btn_o[3] || rise_o[3] || fall_o[3]) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midreset_after: channel 3 active, got 1 want 0");
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        btn = 4'hF;
        wait_btn(0, ok);
        checks++;
        if (!ok || rise_o !== 4'hF || btn_o !== 4'hF) begin
            errors++;
            $display("FAIL simul_rise: ok=%0d rise_o=%h btn_o=%h want 1 f f", ok, rise_o, btn_o);
        end
        tick();
        checks++;
        if (rise_o !== 4'h0) begin
            errors++;
            $display("FAIL simul_rise_width: rise_o=%h want 0", rise_o);
        end
    endtask

    task automatic test_random();
        int hold [CH];
        for (int k = 0; k < CH; k++) hold[k] = 0;
        for (int i = 0; i < 1600; i++) begin
            tp_always = (i >= 1100);
            for (int k = 0; k < CH; k++) begin
                if (hold[k] == 0) begin
                    btn[k]  = 1'($urandom);
                    hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                          : int'($urandom_range(20, 300));
                end
                hold[k]--;
            end
            tick();
            checks++;
            if (btn_o !== m_level) begin
                errors++;
                $display("FAIL rand_btn cyc=%0d: got %h want %h", cyc, btn_o, m_level);
            end
            checks++;
            if (rise_o !== exp_rise || fall_o !== exp_fall) begin
                errors++;
                $display("FAIL rand_edges cyc=%0d: rise=%h fall=%h want %h %h",
                         cyc, rise_o, fall_o, exp_rise, exp_fall);
            end
            checks++;
            if (long_o !== exp_long) begin
                errors++;
                $display("FAIL rand_long cyc=%0d: got %h want %h", cyc, long_o, exp_long);
            end
            checks++;
            if ((rise_o & fall_o) !== 4'h0) begin
                errors++;
                $display("FAIL rand_exclusive cyc=%0d: rise&fall=%h want 0", cyc, rise_o & fall_o);
            end
        end
        tp_always = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bounce();
        test_lockout();
        test_long();
        test_mid_reset();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
